// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle of requester-side and UART-TX-side signals used by
// uart_tx_arbiter.
// Handshake: a requester holds req[i] high with its req_data slice and
// req_last[i] stable until it sees the one-cycle req_ack[i] pulse, then it
// advances to its next byte. The arbiter launches each byte with a one-cycle
// tx_valid pulse, and tx_data stays stable until the next launch. The TX FSM
// answers with tx_busy, and the falling edge of tx_busy marks the end of the
// frame.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            grant;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_busy;
    logic                          err_timeout;

    // Arbiter side
    modport master (
        input  req, req_data, req_last, tx_busy,
        output req_ack, grant, tx_data, tx_valid, err_timeout
    );

    // Requesters and TX datapath side
    modport slave (
        output req, req_data, req_last, tx_busy,
        input  req_ack, grant, tx_data, tx_valid, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and byte sequencer that shares one UART
// transmitter between NUM_REQ requesters. A requester owns the transmitter for
// a whole packet. Each byte is launched with a one-cycle tx_valid pulse and is
// followed through tx_busy until the frame ends.
// Optional launch watchdog: define UART_TX_ARB_TIMEOUT_EN. When it is enabled,
// the packet is abandoned and err_timeout pulses if tx_busy does not rise
// within TIMEOUT_CYCLES cycles after a launch.
// All outputs are registered. o_dbg_state exposes the FSM state
// (0 IDLE, 1 LAUNCH, 2 WAIT_BUSY, 3 WAIT_DONE, 4 HOLD).
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_tx_arbiter_if.master       io_bus,
    output logic [2:0]              o_dbg_state
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [PTR_W-1:0]      r_ptr,      w_ptr_nxt;
    logic [NUM_REQ-1:0]    r_grant,    w_grant_nxt;
    logic [NUM_REQ-1:0]    r_req_ack,  w_req_ack_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data,  w_tx_data_nxt;
    logic                  r_tx_valid, w_tx_valid_nxt;
    logic                  r_last,     w_last_nxt;

    logic [PTR_W-1:0]      w_winner;
    logic                  w_found;
    logic [PTR_W:0]        w_sum;
    logic [NUM_REQ-1:0]    w_win_onehot;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;
    logic                  w_sel_req;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_err, w_err_nxt;
`endif

    // Round-robin search: the first requesting index after r_ptr, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && io_bus.req[w_sum[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[PTR_W-1:0];
            end
        end
    end

    // Select the current owner's inputs and build the one-hot form of the winner.
    always_comb begin
        w_sel_data   = '0;
        w_sel_last   = 1'b0;
        w_sel_req    = 1'b0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_ptr == PTR_W'(i)) begin
                w_sel_data = io_bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last = io_bus.req_last[i];
                w_sel_req  = io_bus.req[i];
            end
            if (w_winner == PTR_W'(i)) begin
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_req_ack_nxt  = '0;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_last_nxt     = r_last;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // The pointer moves only here, so a packet is never interrupted.
                if (w_found) begin
                    w_grant_nxt = w_win_onehot;
                    w_ptr_nxt   = w_winner;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_sel_data;
                w_req_ack_nxt  = r_grant;
                w_last_nxt     = w_sel_last;
`ifdef UART_TX_ARB_TIMEOUT_EN
                w_cnt_nxt      = '0;
`endif
                w_state_nxt    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (io_bus.tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // The transmitter never answered: abandon the packet and keep the pointer.
                    w_err_nxt   = 1'b1;
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (!io_bus.tx_busy) begin
                    if (r_last) begin
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else if (w_sel_req) begin
                        w_state_nxt = S_LAUNCH;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // The grant stays with the owner until it presents the next byte.
                if (w_sel_req) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_W'(NUM_REQ - 1);
            r_grant    <= '0;
            r_req_ack  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_last     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_cnt      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_req_ack  <= w_req_ack_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_last     <= w_last_nxt;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
`endif
        end
    end

    assign io_bus.grant    = r_grant;
    assign io_bus.req_ack  = r_req_ack;
    assign io_bus.tx_valid = r_tx_valid;
    assign io_bus.tx_data  = r_tx_data;
    assign o_dbg_state     = r_state;

`ifdef UART_TX_ARB_TIMEOUT_EN
    assign io_bus.err_timeout = r_err;
`else
    // Without the watchdog, err_timeout never fires; TIMEOUT_CYCLES is only
    // referenced here so that the parameter list is the same in both builds.
    assign io_bus.err_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter. It runs directed
// scenarios and randomized multi-packet traffic. The randomized traffic is
// checked against a packet-level round-robin reference model. The timeout
// scenario is built only when UART_TX_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] dbg_state;
    int         errors = 0;
    int         checks = 0;

    // Transmitter model controls
    int busy_left = 0;
    int busy_len  = 3;
    bit busy_rand = 1'b0;
    bit busy_en   = 1'b1;

    // Random traffic: per-requester source queues, model copies, and expected {grant, data}
    logic [8:0]      src_q [N][$];
    logic [8:0]      mq    [N][$];
    logic [N+DW-1:0] exp_q [$];

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

    uart_tx_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .io_bus(bus), .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    // UART TX model: busy rises right after a launch pulse and stays high for the frame length
    always @(negedge CLK) begin
        if (busy_left > 0) busy_left--;
        else if (bus.tx_valid === 1'b1 && busy_en) busy_left = busy_rand ? int'($urandom_range(1, 8)) : busy_len;
        bus.tx_busy = (busy_left > 0);
    end

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.req_last = '0;
        busy_en = 1'b1; busy_rand = 1'b0; busy_len = 3;
        for (int i = 0; i < 60 && busy_left > 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.req_last = '0;
        repeat (3) @(negedge CLK);
        checks++; if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
        checks++; if (bus.req_ack !== '0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", bus.req_ack); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.tx_valid); end
        checks++; if (bus.tx_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.tx_data); end
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_timeout); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        RST = 1'b0;
    endtask

    task automatic test_single_byte();
        apply_reset();
        busy_len = 10;
        bus.req_data[7:0] = 8'hA5; bus.req_last = 4'b0001; bus.req = 4'b0001;
        @(negedge CLK);
        checks++; if (bus.grant !== 4'b0001 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single_grant: got grant=%b valid=%b expected 0001/0", bus.grant, bus.tx_valid); end
        @(negedge CLK);
        checks++; if (bus.tx_valid !== 1'b1 || bus.req_ack !== 4'b0001 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_launch: got valid=%b ack=%b data=%h expected 1/0001/a5", bus.tx_valid, bus.req_ack, bus.tx_data); end
        bus.req = '0;
        @(negedge CLK);
        checks++; if (bus.tx_valid !== 1'b0 || bus.req_ack !== '0) begin errors++; $display("FAIL single_pulse: got valid=%b ack=%b expected 0/0000", bus.tx_valid, bus.req_ack); end
        repeat (9) @(negedge CLK);
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL single_grant_hold: got %b expected 0001", bus.grant); end
        @(negedge CLK);
        checks++; if (bus.grant !== '0 || dbg_state !== 3'd0) begin errors++; $display("FAIL single_release: got grant=%b state=%0d expected 0000/0", bus.grant, dbg_state); end
        checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h expected a5", bus.tx_data); end
    endtask

    task automatic test_rotation();
        logic [N-1:0]  exp_g [4];
        logic [DW-1:0] exp_d [4];
        logic [N-1:0]  cur;
        int epoch, vcount;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010;
        exp_d[0] = 8'h10;   exp_d[1] = 8'h21;   exp_d[2] = 8'h10;   exp_d[3] = 8'h21;
        apply_reset();
        bus.req_data[7:0] = 8'h10; bus.req_data[15:8] = 8'h21;
        bus.req_last = 4'b0011; bus.req = 4'b0011;
        cur = '0; epoch = 0; vcount = 0;
        for (int cyc = 0; cyc < 300 && epoch < 4; cyc++) begin
            @(negedge CLK);
            if (cur != '0 && bus.grant !== cur) begin
                checks++; if (vcount != 1) begin errors++; $display("FAIL rot_valid_count: got %0d expected 1 (epoch %0d)", vcount, epoch); end
                epoch++; vcount = 0;
            end
            if (bus.tx_valid === 1'b1 && epoch < 4) begin
                vcount++;
                checks++; if (bus.grant !== exp_g[epoch] || bus.tx_data !== exp_d[epoch]) begin errors++; $display("FAIL rot_order: got grant=%b data=%h expected %b/%h", bus.grant, bus.tx_data, exp_g[epoch], exp_d[epoch]); end
            end
            cur = bus.grant;
        end
        checks++; if (epoch != 4) begin errors++; $display("FAIL rot_timeout: got %0d grants expected 4", epoch); end
        bus.req = '0;
    endtask

    task automatic test_packet_hold();
        logic [DW-1:0]  b1 [3];
        logic [N+DW-1:0] exp [4];
        int p1, nval, acks1, viol;
        b1[0] = 8'h11; b1[1] = 8'h22; b1[2] = 8'h33;
        exp[0] = {4'b0010, 8'h11}; exp[1] = {4'b0010, 8'h22}; exp[2] = {4'b0010, 8'h33}; exp[3] = {4'b0100, 8'h77};
        apply_reset();
        p1 = 0; nval = 0; acks1 = 0; viol = 0;
        bus.req_data[15:8] = b1[0]; bus.req_data[23:16] = 8'h77;
        bus.req_last = 4'b0100; bus.req = 4'b0110;
        for (int cyc = 0; cyc < 400 && nval < 4; cyc++) begin
            @(negedge CLK);
            if ((nval == 1 || nval == 2) && bus.grant !== 4'b0010) viol++;
            if (bus.tx_valid === 1'b1) begin
                checks++; if ({bus.grant, bus.tx_data} !== exp[nval]) begin errors++; $display("FAIL pkt_order: got %h expected %h", {bus.grant, bus.tx_data}, exp[nval]); end
                nval++;
            end
            if (bus.req_ack[1] === 1'b1) begin
                acks1++; p1++;
                if (p1 >= 3) bus.req[1] = 1'b0;
                else begin bus.req_data[15:8] = b1[p1]; bus.req_last[1] = (p1 == 2); end
            end
            if (bus.req_ack[2] === 1'b1) bus.req[2] = 1'b0;
        end
        checks++; if (nval != 4) begin errors++; $display("FAIL pkt_timeout: got %0d bytes expected 4", nval); end
        checks++; if (acks1 != 3) begin errors++; $display("FAIL pkt_acks: got %0d expected 3", acks1); end
        checks++; if (viol != 0) begin errors++; $display("FAIL pkt_grant_hold: got %0d bad cycles expected 0", viol); end
        bus.req = '0;
    endtask

    task automatic test_hold();
        int seen, viol;
        apply_reset();
        bus.req_data[7:0] = 8'h5A; bus.req_data[31:24] = 8'h3C;
        bus.req_last = 4'b1000; bus.req = 4'b1001;
        seen = 0;
        for (int cyc = 0; cyc < 50 && seen == 0; cyc++) begin
            @(negedge CLK);
            if (bus.tx_valid === 1'b1) seen = 1;
        end
        checks++; if (seen == 0 || bus.grant !== 4'b0001 || bus.tx_data !== 8'h5A) begin errors++; $display("FAIL hold_first: got seen=%0d grant=%b data=%h expected 1/0001/5a", seen, bus.grant, bus.tx_data); end
        bus.req[0] = 1'b0;
        viol = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            if (bus.grant !== 4'b0001 || bus.tx_valid !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL hold_window: got %0d bad cycles expected 0", viol); end
        checks++; if (dbg_state !== 3'd4) begin errors++; $display("FAIL hold_state: got %0d expected 4", dbg_state); end
        bus.req_data[7:0] = 8'h6B; bus.req_last[0] = 1'b1; bus.req[0] = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 50 && seen < 2; cyc++) begin
            @(negedge CLK);
            if (bus.tx_valid === 1'b1) begin
                if (seen == 0) begin
                    checks++; if (bus.grant !== 4'b0001 || bus.tx_data !== 8'h6B) begin errors++; $display("FAIL hold_resume: got grant=%b data=%h expected 0001/6b", bus.grant, bus.tx_data); end
                    bus.req[0] = 1'b0;
                end else begin
                    checks++; if (bus.grant !== 4'b1000 || bus.tx_data !== 8'h3C) begin errors++; $display("FAIL hold_next: got grant=%b data=%h expected 1000/3c", bus.grant, bus.tx_data); end
                    bus.req[3] = 1'b0;
                end
                seen++;
            end
        end
        checks++; if (seen != 2) begin errors++; $display("FAIL hold_timeout: got %0d bytes expected 2", seen); end
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        int found;
        apply_reset();
        busy_len = 20;
        bus.req_data[7:0] = 8'h44; bus.req_data[15:8] = 8'h55;
        bus.req_last = 4'b0011; bus.req = 4'b0001;
        found = 0;
        for (int cyc = 0; cyc < 50 && found == 0; cyc++) begin
            @(negedge CLK);
            if (bus.req_ack[0] === 1'b1) bus.req[0] = 1'b0;
            if (dbg_state === 3'd3) found = 1;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL mid_wait_done: got state=%0d expected 3", dbg_state); end
        RST = 1'b1; bus.req = 4'b0011;
        @(negedge CLK);
        checks++; if (bus.grant !== '0 || bus.req_ack !== '0 || bus.tx_valid !== 1'b0 || bus.tx_data !== '0 || bus.err_timeout !== 1'b0 || dbg_state !== 3'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got grant=%b ack=%b valid=%b data=%h err=%b state=%0d expected all 0", bus.grant, bus.req_ack, bus.tx_valid, bus.tx_data, bus.err_timeout, dbg_state);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", bus.grant); end
        bus.req = '0;
        repeat (40) @(negedge CLK);
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int seen, early;
        apply_reset();
        busy_en = 1'b0;
        bus.req_data[23:16] = 8'h99; bus.req_last = 4'b0100; bus.req = 4'b0100;
        seen = 0;
        for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
            @(negedge CLK);
            if (bus.tx_valid === 1'b1) seen = 1;
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL to_launch: got no launch expected one"); end
        bus.req = '0;
        early = 0;
        for (int k = 1; k < TO; k++) begin
            @(negedge CLK);
            if (bus.err_timeout !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL to_early: got %0d early pulses expected 0", early); end
        @(negedge CLK);
        checks++; if (bus.err_timeout !== 1'b1 || bus.grant !== '0) begin errors++; $display("FAIL to_pulse: got err=%b grant=%b expected 1/0000", bus.err_timeout, bus.grant); end
        @(negedge CLK);
        checks++; if (bus.err_timeout !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL to_single: got err=%b state=%0d expected 0/0", bus.err_timeout, dbg_state); end
        busy_en = 1'b1;
        bus.req_data[15:8] = 8'h01; bus.req_data[31:24] = 8'h03;
        bus.req_last = 4'b1010; bus.req = 4'b1010;
        @(negedge CLK);
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL to_rearb: got %b expected 1000", bus.grant); end
        bus.req = '0;
        repeat (20) @(negedge CLK);
    endtask
`endif

    task automatic test_random(input int rounds);
        int gap [N];
        logic [N-1:0] act, oh;
        logic [8:0] b;
        logic [N+DW-1:0] e;
        int ptr, win, found, done, npk, len;
        for (int r = 0; r < rounds; r++) begin
            apply_reset();
            busy_rand = 1'b1;
            exp_q.delete();
            act = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                src_q[i].delete();
                gap[i] = 0;
                if (act[i]) begin
                    npk = $urandom_range(1, 3);
                    for (int p = 0; p < npk; p++) begin
                        len = $urandom_range(1, 4);
                        for (int k = 0; k < len; k++) src_q[i].push_back({(k == len - 1), 8'($urandom_range(0, 255))});
                    end
                end
                mq[i] = src_q[i];
            end
            // Reference model: whole packets in round-robin order starting after requester N-1
            ptr = N - 1;
            forever begin
                found = 0; win = 0;
                for (int k = 1; k <= N; k++) begin
                    if (found == 0 && mq[(ptr + k) % N].size() > 0) begin found = 1; win = (ptr + k) % N; end
                end
                if (found == 0) break;
                oh = '0; oh[win] = 1'b1;
                do begin
                    b = mq[win].pop_front();
                    exp_q.push_back({oh, b[7:0]});
                end while (b[8] == 1'b0 && mq[win].size() > 0);
                ptr = win;
            end
            // Present the first byte of every requester
            for (int i = 0; i < N; i++) begin
                bus.req[i] = (src_q[i].size() > 0);
                if (src_q[i].size() > 0) begin bus.req_data[i*DW +: DW] = src_q[i][0][7:0]; bus.req_last[i] = src_q[i][0][8]; end
            end
            done = 0;
            for (int cyc = 0; cyc < 5000 && done == 0; cyc++) begin
                @(negedge CLK);
                if (bus.tx_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra: got %h expected no launch", {bus.grant, bus.tx_data}); end
                    else begin
                        e = exp_q.pop_front();
                        if ({bus.grant, bus.tx_data} !== e) begin errors++; $display("FAIL rnd_byte: got %h expected %h", {bus.grant, bus.tx_data}, e); end
                    end
                    checks++; if (bus.req_ack !== bus.grant) begin errors++; $display("FAIL rnd_ack: got %b expected %b", bus.req_ack, bus.grant); end
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.req_ack[i] === 1'b1 && src_q[i].size() > 0) begin
                        b = src_q[i].pop_front();
                        gap[i] = (b[8] == 1'b0) ? int'($urandom_range(0, 3)) : 0;
                    end else if (gap[i] > 0) gap[i]--;
                    bus.req[i] = (src_q[i].size() > 0 && gap[i] == 0);
                    if (src_q[i].size() > 0) begin bus.req_data[i*DW +: DW] = src_q[i][0][7:0]; bus.req_last[i] = src_q[i][0][8]; end
                end
                if (exp_q.size() == 0 && bus.req == '0 && dbg_state === 3'd0) done = 1;
            end
            checks++; if (done == 0 || exp_q.size() != 0) begin errors++; $display("FAIL rnd_timeout: got %0d bytes left expected 0", exp_q.size()); end
            bus.req = '0;
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.req_last = '0;
        test_reset();
        test_single_byte();
        test_rotation();
        test_packet_hold();
        test_hold();
        test_reset_mid();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
